// File: rtl/rx_bit_destuff_if.sv
// ============================================================================
// Module   : rx_bit_destuff_if
// Purpose  : Handshake/bus bundle between the line sampler, the receive bit
//            unstuffer and the receive packet decoder.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   d_encoded    sampler -> unstuffer  sampled NRZI line bit
//   shift_enable sampler -> unstuffer  one-cycle bit strobe
//   eop          sampler -> unstuffer  end of packet / line reset
//   d_orig       unstuffer -> decoder  last decoded data bit
//   bit_valid    unstuffer -> decoder  d_orig holds a fresh data bit
//   stuff_skip   unstuffer -> decoder  strobed bit was a dropped stuff bit
//   stuff_err    unstuffer -> decoder  sticky stuffing violation
//   rx_byte      unstuffer -> decoder  assembled byte (LSB first on line)
//   byte_ready   unstuffer -> decoder  rx_byte complete
//   stuff_count  unstuffer -> decoder  saturating stuff-bit count, present
//                                      only when RX_DESTUFF_STATS_EN is defined
// Modports: master = line sampler side (drives strobes), slave = unstuffer.
// ============================================================================
`default_nettype none

interface rx_bit_destuff_if;
  logic       d_encoded;
  logic       shift_enable;
  logic       eop;
  logic       d_orig;
  logic       bit_valid;
  logic       stuff_skip;
  logic       stuff_err;
  logic [7:0] rx_byte;
  logic       byte_ready;
`ifdef RX_DESTUFF_STATS_EN
  logic [7:0] stuff_count;

  modport master (
    output d_encoded, shift_enable, eop,
    input  d_orig, bit_valid, stuff_skip, stuff_err, rx_byte, byte_ready,
           stuff_count
  );

  modport slave (
    input  d_encoded, shift_enable, eop,
    output d_orig, bit_valid, stuff_skip, stuff_err, rx_byte, byte_ready,
           stuff_count
  );
`else
  modport master (
    output d_encoded, shift_enable, eop,
    input  d_orig, bit_valid, stuff_skip, stuff_err, rx_byte, byte_ready
  );

  modport slave (
    input  d_encoded, shift_enable, eop,
    output d_orig, bit_valid, stuff_skip, stuff_err, rx_byte, byte_ready
  );
`endif
endinterface

`default_nettype wire

// File: rtl/rx_bit_destuff.sv
// ============================================================================
// Module   : rx_bit_destuff
// Purpose  : Receive-side bit unstuffer. NRZI-decodes each strobed line bit,
//            drops the stuff 0 that follows every run of ONES_LIMIT decoded
//            1s, flags a sticky violation when that 0 is missing, and packs
//            the surviving data bits LSB-first into bytes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ONES_LIMIT   decoded-1 run length after which a stuff 0 is mandatory
//                (legal range 2..15, default 6)
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   bus          slave modport of rx_bit_destuff_if (strobe inputs, all
//                result outputs; every output is registered)
// Configuration macro:
//   RX_DESTUFF_STATS_EN  when defined, adds bus.stuff_count, a saturating
//                        8-bit count of dropped stuff bits cleared by eop.
// ============================================================================
`default_nettype none

module rx_bit_destuff #(
  parameter int unsigned ONES_LIMIT = 6
) (
  input  logic            clk,
  input  logic            n_rst,
  rx_bit_destuff_if.slave bus
);

  // Run length at which the next strobed bit must be a stuff 0.
  localparam logic [3:0] C_LIMIT = 4'(ONES_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,  // ones_cnt == 0
    ST_RUN          = 2'd1,  // 1 <= ones_cnt < ONES_LIMIT
    ST_EXPECT_STUFF = 2'd2,  // ones_cnt == ONES_LIMIT, stuff 0 due
    ST_ERROR        = 2'd3   // violation seen, waiting for eop
  } state_t;

  // --------------------------------------------------------------------------
  // State registers and their next-state values
  // --------------------------------------------------------------------------
  state_t     state_q,      state_d;
  logic       nrzi_prev_q,  nrzi_prev_d;
  logic [3:0] ones_cnt_q,   ones_cnt_d;
  logic [2:0] bit_cnt_q,    bit_cnt_d;

  // Registered outputs
  logic       d_orig_q,     d_orig_d;
  logic       bit_valid_q,  bit_valid_d;
  logic       stuff_skip_q, stuff_skip_d;
  logic       stuff_err_q,  stuff_err_d;
  logic [7:0] rx_byte_q,    rx_byte_d;
  logic       byte_ready_q, byte_ready_d;

`ifdef RX_DESTUFF_STATS_EN
  logic [7:0] stuff_count_q, stuff_count_d;
`endif

  // Combinational helpers
  logic       w_dec;        // NRZI-decoded value of the strobed bit
  logic [3:0] w_ones_inc;   // run length if the strobed bit is a 1

  // A line level that did not change decodes to 1.
  assign w_dec      = (bus.d_encoded == nrzi_prev_q);
  assign w_ones_inc = ones_cnt_q + 4'd1;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Hold everything by default; pulse outputs fall back to 0 each cycle.
    state_d      = state_q;
    nrzi_prev_d  = nrzi_prev_q;
    ones_cnt_d   = ones_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    d_orig_d     = d_orig_q;
    bit_valid_d  = 1'b0;
    stuff_skip_d = 1'b0;
    stuff_err_d  = stuff_err_q;
    rx_byte_d    = rx_byte_q;
    byte_ready_d = 1'b0;
`ifdef RX_DESTUFF_STATS_EN
    stuff_count_d = stuff_count_q;
`endif

    if (bus.eop) begin
      // End of packet has priority over a coincident strobe: the strobed bit
      // is discarded and the line reference returns to its idle level. The
      // last data bit and last byte stay visible to the decoder.
      state_d     = ST_IDLE;
      nrzi_prev_d = 1'b1;
      ones_cnt_d  = 4'd0;
      bit_cnt_d   = 3'd0;
      stuff_err_d = 1'b0;
`ifdef RX_DESTUFF_STATS_EN
      stuff_count_d = 8'h00;
`endif
    end else if (bus.shift_enable) begin
      // The NRZI reference follows the line on every strobe, stuff bits and
      // ignored bits included, so decoding stays aligned after errors.
      nrzi_prev_d = bus.d_encoded;

      case (state_q)
        ST_IDLE, ST_RUN: begin
          // Ordinary data bit: emit it and shift it into the byte from the
          // top so the first bit on the line ends up in bit 0.
          d_orig_d     = w_dec;
          bit_valid_d  = 1'b1;
          rx_byte_d    = {w_dec, rx_byte_q[7:1]};
          bit_cnt_d    = bit_cnt_q + 3'd1;
          byte_ready_d = (bit_cnt_q == 3'd7);

          if (w_dec) begin
            ones_cnt_d = w_ones_inc;
            state_d    = (w_ones_inc == C_LIMIT) ? ST_EXPECT_STUFF : ST_RUN;
          end else begin
            ones_cnt_d = 4'd0;
            state_d    = ST_IDLE;
          end
        end

        ST_EXPECT_STUFF: begin
          if (!w_dec) begin
            // Legal stuff bit: drop it without touching the byte position.
            stuff_skip_d = 1'b1;
            ones_cnt_d   = 4'd0;
            state_d      = ST_IDLE;
`ifdef RX_DESTUFF_STATS_EN
            if (stuff_count_q != 8'hFF) begin
              stuff_count_d = stuff_count_q + 8'd1;
            end
`endif
          end else begin
            // A 1 where the stuff 0 was mandatory: lock up until eop.
            stuff_err_d = 1'b1;
            state_d     = ST_ERROR;
          end
        end

        ST_ERROR: begin
          // Bits are ignored; only the NRZI reference (above) moves.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      nrzi_prev_q  <= 1'b1;
      ones_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      d_orig_q     <= 1'b0;
      bit_valid_q  <= 1'b0;
      stuff_skip_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      rx_byte_q    <= 8'h00;
      byte_ready_q <= 1'b0;
`ifdef RX_DESTUFF_STATS_EN
      stuff_count_q <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      nrzi_prev_q  <= nrzi_prev_d;
      ones_cnt_q   <= ones_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      d_orig_q     <= d_orig_d;
      bit_valid_q  <= bit_valid_d;
      stuff_skip_q <= stuff_skip_d;
      stuff_err_q  <= stuff_err_d;
      rx_byte_q    <= rx_byte_d;
      byte_ready_q <= byte_ready_d;
`ifdef RX_DESTUFF_STATS_EN
      stuff_count_q <= stuff_count_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.d_orig     = d_orig_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.stuff_skip = stuff_skip_q;
  assign bus.stuff_err  = stuff_err_q;
  assign bus.rx_byte    = rx_byte_q;
  assign bus.byte_ready = byte_ready_q;
`ifdef RX_DESTUFF_STATS_EN
  assign bus.stuff_count = stuff_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_bit_destuff.sv
// ============================================================================
// Module   : tb_rx_bit_destuff
// Purpose  : Self-checking bench for rx_bit_destuff: directed vector table,
//            asynchronous-reset sequence and randomized strobes, all compared
//            against a bit-level behavioural model kept in this file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_bit_destuff;

  localparam int LIMIT = 6;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  rx_bit_destuff_if bus();

  rx_bit_destuff #(.ONES_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // --------------------------------------------------------------------------
  // Behavioural model: line history, run length and data-bit history.
  // --------------------------------------------------------------------------
  bit m_prev;          // last line level seen on a strobe
  int m_run;           // decoded 1s since the last 0 / stuff bit
  bit m_err;           // violation seen since last eop
  int m_bits;          // data bits since last eop
  bit hist[$];         // last 8 data bits, oldest first
  bit e_dorig, e_bv, e_skip, e_br;
  int e_cnt;

  task automatic model_reset();
    m_prev = 1'b1; m_run = 0; m_err = 1'b0; m_bits = 0;
    hist.delete();
    repeat (8) hist.push_back(1'b0);
    e_dorig = 1'b0; e_bv = 1'b0; e_skip = 1'b0; e_br = 1'b0; e_cnt = 0;
  endtask

  function automatic logic [7:0] m_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = hist[i];
    return b;
  endfunction

  task automatic model_step(bit se, bit line, bit eop);
    bit dec;
    e_bv = 1'b0; e_skip = 1'b0; e_br = 1'b0;
    if (eop) begin
      m_prev = 1'b1; m_run = 0; m_err = 1'b0; m_bits = 0; e_cnt = 0;
    end else if (se) begin
      dec    = (line == m_prev);
      m_prev = line;
      if (!m_err) begin
        if (m_run == LIMIT) begin
          if (!dec) begin
            e_skip = 1'b1;
            m_run  = 0;
            if (e_cnt < 255) e_cnt++;
          end else begin
            m_err = 1'b1;
          end
        end else begin
          e_dorig = dec;
          e_bv    = 1'b1;
          hist.push_back(dec);
          void'(hist.pop_front());
          m_bits++;
          e_br  = (m_bits % 8 == 0);
          m_run = dec ? m_run + 1 : 0;
        end
      end
    end
  endtask

  // Line level that makes the model decode 'dec' next.
  function automatic bit enc(bit dec);
    return dec ? m_prev : ~m_prev;
  endfunction

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_d_orig",     {7'd0, bus.d_orig},     {7'd0, e_dorig});
    chk("m_bit_valid",  {7'd0, bus.bit_valid},  {7'd0, e_bv});
    chk("m_stuff_skip", {7'd0, bus.stuff_skip}, {7'd0, e_skip});
    chk("m_stuff_err",  {7'd0, bus.stuff_err},  {7'd0, m_err});
    chk("m_byte_ready", {7'd0, bus.byte_ready}, {7'd0, e_br});
    chk("m_rx_byte",    bus.rx_byte,            m_byte());
`ifdef RX_DESTUFF_STATS_EN
    chk("m_stuff_count", bus.stuff_count,       8'(e_cnt));
`endif
  endtask

  // Entered at posedge+1; applies one cycle of inputs and checks results.
  task automatic drive(bit se, bit line, bit eop);
    bus.shift_enable = se;
    bus.d_encoded    = line;
    bus.eop          = eop;
    @(posedge clk);
    model_step(se, line, eop);
    #1;
    check_model();
    bus.shift_enable = 1'b0;
    bus.eop          = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    bit         se;
    bit         dec;
    bit         eop;
    bit         bv;
    bit         skip;
    bit         err;
    bit         br;
    logic [7:0] rxb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit se, bit dec, bit eop, bit bv, bit skip, bit err,
                     bit br, logic [7:0] rxb);
    vec_t v;
    v.se = se; v.dec = dec; v.eop = eop; v.bv = bv; v.skip = skip;
    v.err = err; v.br = br; v.rxb = rxb;
    tbl.push_back(v);
  endtask

  task automatic add_byte(logic [7:0] b);
    for (int i = 0; i < 8; i++) add(1, b[i], 0, 1, 0, 0, i == 7, b);
  endtask

  task automatic add_eop(bit err_before);
    if (err_before) add(0, 0, 0, 0, 0, 1, 0, 8'h00);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00);
  endtask

  // Six 1s, stuff 0, two 1s; 'gap' idle cycles between strobes.
  task automatic add_stuffed(int gap);
    for (int i = 0; i < 9; i++) begin
      add(1, i != 6, 0, i != 6, i == 6, 0, i == 8, 8'hFF);
      if (i != 8) for (int g = 0; g < gap; g++) add(0, 0, 0, 0, 0, 0, 0, 8'h00);
    end
  endtask

  task automatic build_table();
    logic [7:0] b;
    add_byte(8'hA5);
    add_eop(0);
    add_stuffed(0);
    add_eop(0);
    add_stuffed(3);
    add_eop(0);
    // Violation: seventh 1 where the stuff 0 belongs, then ignored strobes.
    for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 0, 0, 0, 8'h00);
    add(1, 1, 0, 0, 0, 1, 0, 8'h00);
    b = 8'b0001_0101;
    for (int i = 0; i < 5; i++) add(1, b[i], 0, 0, 0, 1, 0, 8'h00);
    add_eop(1);
    add_byte(8'h3C);
    add_eop(0);
    // Partial byte discarded by eop coinciding with a strobe.
    add(1, 1, 0, 1, 0, 0, 0, 8'h00);
    add(1, 0, 0, 1, 0, 0, 0, 8'h00);
    add(1, 1, 0, 1, 0, 0, 0, 8'h00);
    add(1, 1, 1, 0, 0, 0, 0, 8'h00);
    add_byte(8'h81);
  endtask

  task automatic run_table();
    foreach (tbl[k]) begin
      drive(tbl[k].se, enc(tbl[k].dec), tbl[k].eop);
      chk("tbl_bit_valid",  {7'd0, bus.bit_valid},  {7'd0, tbl[k].bv});
      chk("tbl_stuff_skip", {7'd0, bus.stuff_skip}, {7'd0, tbl[k].skip});
      chk("tbl_stuff_err",  {7'd0, bus.stuff_err},  {7'd0, tbl[k].err});
      chk("tbl_byte_ready", {7'd0, bus.byte_ready}, {7'd0, tbl[k].br});
      if (tbl[k].bv) chk("tbl_d_orig", {7'd0, bus.d_orig}, {7'd0, tbl[k].dec});
      if (tbl[k].br) chk("tbl_rx_byte", bus.rx_byte, tbl[k].rxb);
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    bus.shift_enable = 1'b0;
    bus.d_encoded    = 1'b0;
    bus.eop          = 1'b0;
    n_rst            = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_rx_byte",    bus.rx_byte,              8'h00);
    chk("reset_bit_valid",  {7'd0, bus.bit_valid},    8'h00);
    chk("reset_stuff_err",  {7'd0, bus.stuff_err},    8'h00);
    check_model();

    build_table();
    run_table();

    // Asynchronous reset mid-byte: outputs clear before any clock edge.
    drive(1, enc(1'b1), 0);
    drive(1, enc(1'b1), 0);
    drive(1, enc(1'b0), 0);
    #3;
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_d_orig",     {7'd0, bus.d_orig},     8'h00);
    chk("async_rst_bit_valid",  {7'd0, bus.bit_valid},  8'h00);
    chk("async_rst_stuff_skip", {7'd0, bus.stuff_skip}, 8'h00);
    chk("async_rst_stuff_err",  {7'd0, bus.stuff_err},  8'h00);
    chk("async_rst_rx_byte",    bus.rx_byte,            8'h00);
    chk("async_rst_byte_ready", {7'd0, bus.byte_ready}, 8'h00);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    drive(1, 1'b1, 0);
    chk("post_rst_d_orig",    {7'd0, bus.d_orig},    8'h01);
    chk("post_rst_bit_valid", {7'd0, bus.bit_valid}, 8'h01);

    // Randomized strobes, spacing, runs and eops against the model.
    for (int n = 0; n < 4000; n++) begin
      bit se, eop, dec, line;
      se   = ($urandom_range(0, 3) != 0);
      eop  = ($urandom_range(0, 79) == 0);
      if (m_run == LIMIT) dec = ($urandom_range(0, 3) == 0);
      else                dec = ($urandom_range(0, 7) != 0);
      line = enc(dec);
      drive(se, line, eop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
